dmem_arbiter: RTL and testbench

- Arbitrates the single 16-bit data memory between two requesters: the CPU load/store path (port C) and the program/debug loader (port L).
- Sequences every access as ISSUE then RESP.
- Drives the stall that freezes the single-cycle core's PC and register writeback while a CPU access is pending.
- Sits between CPU_16_TOP's data-memory port and the synchronous data RAM.

---
 rtl/dmem_arbiter_if.sv | 56 +++++
 rtl/dmem_arbiter.sv | 124 ++++++++++++
 tb/tb_dmem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, loader and RAM signals around the data-memory arbiter.
// conflict_cnt exists only when DMEM_ARB_STATS_EN is defined.
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          ldr_req;
  logic          ldr_we;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata;
  logic          ldr_ack;
  logic [DW-1:0] ldr_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   conflict_cnt;
`endif

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_stall,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_ack, ldr_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
`ifdef DMEM_ARB_STATS_EN
    , output conflict_cnt
`endif
  );

  // Requester / RAM side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_stall,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_ack, ldr_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
`ifdef DMEM_ARB_STATS_EN
    , input conflict_cnt
`endif
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / loader) arbiter for the single-ported data RAM: ISSUE then RESP per access.
// Define DMEM_ARB_STATS_EN to add the saturating conflict_cnt statistic.
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

  state_t        state_reg, state_next;
  logic          owner_reg, owner_next;   // 0 = CPU, 1 = loader
  logic          we_reg, we_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [DW-1:0] wdata_reg, wdata_next;
  logic [3:0]    wait_reg, wait_next;

  logic arb_point;
  logic any_req;
  logic both_req;
  logic ldr_wins;
  logic rd_done;
  logic cpu_ack;
  logic ldr_ack;

  assign arb_point = (state_reg == IDLE) || (state_reg == RESP);
  assign any_req   = bus.cpu_req | bus.ldr_req;
  assign both_req  = bus.cpu_req & bus.ldr_req;
  // Loader wins when alone, or when it has lost MAX_WAIT times in a row
  assign ldr_wins  = bus.ldr_req & (~bus.cpu_req | (wait_reg == MAX_WAIT_L));
  assign rd_done   = (state_reg == RESP) && !we_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wait_reg  <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      wait_reg  <= wait_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    wait_next  = wait_reg;
    unique case (state_reg)
      ISSUE: state_next = RESP;
      default: begin
        if (any_req) begin
          state_next = ISSUE;
          owner_next = ldr_wins;
          if (ldr_wins) begin
            we_next    = bus.ldr_we;
            addr_next  = bus.ldr_addr;
            wdata_next = bus.ldr_wdata;
            wait_next  = '0;
          end else begin
            we_next    = bus.cpu_we;
            addr_next  = bus.cpu_addr;
            wdata_next = bus.cpu_wdata;
            if (both_req) wait_next = wait_reg + 4'd1;
          end
        end else begin
          state_next = IDLE;
        end
      end
    endcase
  end

  // Per-requester read-data registers; index 0 = CPU, 1 = loader
  for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
    logic [DW-1:0] rdata_reg;
    logic          load;
    assign load = rd_done && (owner_reg == 1'(gi));
    always_ff @(posedge clk) begin
      if (reset)     rdata_reg <= '0;
      else if (load) rdata_reg <= bus.mem_rdata;
    end
  end

  assign cpu_ack       = (state_reg == RESP) && !owner_reg;
  assign ldr_ack       = (state_reg == RESP) &&  owner_reg;
  assign bus.cpu_ack   = cpu_ack;
  assign bus.ldr_ack   = ldr_ack;
  assign bus.cpu_rdata = g_rdata[0].rdata_reg;
  assign bus.ldr_rdata = g_rdata[1].rdata_reg;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_ack;

  assign bus.mem_en    = (state_reg == ISSUE);
  assign bus.mem_we    = (state_reg == ISSUE) && we_reg;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conflict_reg;
  always_ff @(posedge clk) begin
    if (reset)
      conflict_reg <= '0;
    else if (arb_point && both_req && (conflict_reg != 16'hFFFF))
      conflict_reg <= conflict_reg + 16'd1;
  end
  assign bus.conflict_cnt = conflict_reg;
`endif

  a_wait_bound: assert property (@(posedge clk) wait_reg <= MAX_WAIT_L);
  a_one_ack:    assert property (@(posedge clk) !(cpu_ack && ldr_ack));
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against an edge-level reference model of the arbitration rules.
// Also exercises DMEM_ARB_STATS_EN when that macro is defined.
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Synchronous RAM seen by the arbiter
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 access on bus, 2 completion
  int m_phase, m_owner, m_we, m_addr, m_wdata, m_wcnt, m_conf;
  int m_rd [2];
  int refmem [256];

  task automatic model_edge();
    int c, l, win_l;
    if (m_phase == 1 && m_we != 0) refmem[m_addr] = m_wdata;
    if (reset) begin
      m_phase = 0; m_owner = 0; m_we = 0; m_addr = 0; m_wdata = 0;
      m_wcnt = 0; m_conf = 0; m_rd[0] = 0; m_rd[1] = 0;
      return;
    end
    if (m_phase == 1) begin
      m_phase = 2;
      return;
    end
    if (m_phase == 2 && m_we == 0) m_rd[m_owner] = refmem[m_addr];
    c = int'(bus.cpu_req);
    l = int'(bus.ldr_req);
    if (c != 0 && l != 0 && m_conf < 65535) m_conf++;
    if (c == 0 && l == 0) begin
      m_phase = 0;
      return;
    end
    win_l = (l != 0 && (c == 0 || m_wcnt == MAX_WAIT)) ? 1 : 0;
    if (win_l != 0)  m_wcnt = 0;
    else if (l != 0) m_wcnt++;
    m_owner = win_l;
    m_we    = win_l ? int'(bus.ldr_we)    : int'(bus.cpu_we);
    m_addr  = win_l ? int'(bus.ldr_addr)  : int'(bus.cpu_addr);
    m_wdata = win_l ? int'(bus.ldr_wdata) : int'(bus.cpu_wdata);
    m_phase = 1;
  endtask

  function automatic logic exp_ack(input int port);
    return (m_phase == 2 && m_owner == port);
  endfunction

  task automatic check_all();
    chk("mem_en",    bus.mem_en,    m_phase == 1);
    chk("mem_we",    bus.mem_we,    m_phase == 1 && m_we != 0);
    chk("mem_addr",  bus.mem_addr,  m_addr);
    chk("mem_wdata", bus.mem_wdata, m_wdata);
    chk("cpu_ack",   bus.cpu_ack,   exp_ack(0));
    chk("ldr_ack",   bus.ldr_ack,   exp_ack(1));
    chk("cpu_rdata", bus.cpu_rdata, m_rd[0]);
    chk("ldr_rdata", bus.ldr_rdata, m_rd[1]);
    chk("cpu_stall", bus.cpu_stall, bus.cpu_req && !exp_ack(0));
`ifdef DMEM_ARB_STATS_EN
    chk("conflict_cnt", bus.conflict_cnt, m_conf);
`endif
    if (m_phase == 2)
      $display("txn %s %s addr=%02h data=%04h", (m_owner != 0) ? "L" : "C",
               (m_we != 0) ? "wr" : "rd", m_addr,
               (m_we != 0) ? m_wdata : refmem[m_addr]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_port(input int port, input logic req, input logic we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (port == 0) begin
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    end else begin
      bus.ldr_req = req; bus.ldr_we = we; bus.ldr_addr = addr; bus.ldr_wdata = wdata;
    end
  endtask

  // Single transaction on one port; returns cycles from request to ack
  task automatic do_single(input int port, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, output int lat);
    lat = 0;
    set_port(port, 1'b1, we, addr, wdata);
    for (int n = 1; n <= 8; n++) begin
      step();
      if (exp_ack(port)) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) chk("ack_timeout", 1, 0);
    set_port(port, 1'b0, we, addr, wdata);
  endtask

  task automatic new_txn(input int port);
    set_port(port, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), 16'($urandom));
  endtask

  task automatic agents();
    for (int p = 0; p < 2; p++) begin
      logic req;
      req = (p == 0) ? bus.cpu_req : bus.ldr_req;
      if (req && exp_ack(p)) begin
        if ($urandom_range(0, 9) < 7) new_txn(p);
        else if (p == 0) bus.cpu_req = 1'b0;
        else bus.ldr_req = 1'b0;
      end else if (!req && $urandom_range(0, 1) == 1) begin
        new_txn(p);
      end
    end
  endtask

  initial begin
    int lat;
    string exp_order;
    string got_order;
    int acks;

    m_phase = 0; m_owner = 0; m_we = 0; m_addr = 0; m_wdata = 0;
    m_wcnt = 0; m_conf = 0; m_rd[0] = 0; m_rd[1] = 0;
    for (int i = 0; i < 256; i++) refmem[i] = 0;

    // Reset with random inputs
    reset = 1'b1;
    set_port(0, 1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom));
    set_port(1, 1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom));
    step();
    step();
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_addr", bus.mem_addr, 0);
    reset = 1'b0;
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) step();
    chk("idle_acks", {bus.cpu_ack, bus.ldr_ack, bus.mem_en}, 0);

    // Preload RAM window through the loader
    for (int a = 0; a < 32; a++) do_single(1, 1'b1, 8'(a), 16'($urandom), lat);

    // Loader write 0x05 / 0x1234
    set_port(1, 1'b1, 1'b1, 8'h05, 16'h1234);
    step();
    chk("lw_mem_en", bus.mem_en, 1);
    chk("lw_mem_we", bus.mem_we, 1);
    chk("lw_mem_addr", bus.mem_addr, 8'h05);
    chk("lw_mem_wdata", bus.mem_wdata, 16'h1234);
    step();
    chk("lw_ldr_ack", bus.ldr_ack, 1);
    chk("lw_cpu_ack", bus.cpu_ack, 0);
    bus.ldr_req = 1'b0;
    step();

    // CPU read of 0x10 holding 0xBEEF
    do_single(1, 1'b1, 8'h10, 16'hBEEF, lat);
    step();
    set_port(0, 1'b1, 1'b0, 8'h10, 16'h0);
    #1;
    chk("cr_stall_t", bus.cpu_stall, 1);
    step();
    chk("cr_mem_en", bus.mem_en, 1);
    chk("cr_mem_we", bus.mem_we, 0);
    chk("cr_mem_addr", bus.mem_addr, 8'h10);
    chk("cr_stall_t1", bus.cpu_stall, 1);
    step();
    chk("cr_cpu_ack", bus.cpu_ack, 1);
    chk("cr_stall_t2", bus.cpu_stall, 0);
    bus.cpu_req = 1'b0;
    step();
    chk("cr_rdata", bus.cpu_rdata, 16'hBEEF);

    // Both requesters held high: starvation guard
    reset = 1'b1;
    step();
    reset = 1'b0;
    new_txn(0);
    new_txn(1);
    exp_order = "CCCCLCCCCL";
    got_order = "";
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.cpu_ack) begin got_order = {got_order, "C"}; acks++; new_txn(0); end
      if (bus.ldr_ack) begin got_order = {got_order, "L"}; acks++; new_txn(1); end
    end
    chk("grant_acks", acks, 10);
    for (int k = 0; k < 10; k++)
      chk($sformatf("grant_%0d", k), (k < got_order.len()) ? got_order[k] : 8'h3f, exp_order[k]);
    bus.cpu_req = 1'b0;
    bus.ldr_req = 1'b0;
    step();
    step();

    // Reset during ISSUE of a CPU write
    step();
    set_port(0, 1'b1, 1'b1, 8'h0A, 16'hA5A5);
    step();
    chk("ri_issue", bus.mem_en, 1);
    reset = 1'b1;
    bus.cpu_req = 1'b0;
    step();
    chk("ri_no_ack", bus.cpu_ack, 0);
    chk("ri_mem_en", bus.mem_en, 0);
    reset = 1'b0;
    step();
    do_single(0, 1'b0, 8'h0A, 16'h0, lat);
    chk("ri_latency", lat, 2);
    step();

`ifdef DMEM_ARB_STATS_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_port(0, 1'b1, 1'b0, 8'h01, 16'h0);
    set_port(1, 1'b1, 1'b0, 8'h02, 16'h0);
    for (int i = 0; i < 6; i++) step();
    bus.cpu_req = 1'b0;
    bus.ldr_req = 1'b0;
    step();
    do_single(0, 1'b0, 8'h03, 16'h0, lat);
    do_single(1, 1'b0, 8'h04, 16'h0, lat);
    step();
    chk("stats_cnt", bus.conflict_cnt, 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("stats_rst", bus.conflict_cnt, 0);
`endif

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      agents();
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        bus.ldr_req = 1'b0;
      end else begin
        reset = 1'b0;
      end
      step();
    end
    reset = 1'b0;
    bus.cpu_req = 1'b0;
    bus.ldr_req = 1'b0;
    for (int i = 0; i < 4; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
